dct4x4_pass_sequencer: RTL and testbench

Controller that computes a 4x4 forward DCT Y = T * X * T^T by running the existing shared 4x4 matrix-multiply datapath (OpenAV1_forward_DCT: C = A*B, 16 x 8-bit elements per 128-bit bus) twice per block. It accepts one residual block on a valid/ready input, drives the multiplier operands for pass 1 (T*X) and pass 2 (tmp*T^T), holds the intermediate, and presents the result on a valid/ready output. It sits between the residual buffer and the quantiser.

---
 rtl/dct_pkg.sv | 38 +++
 rtl/dct4x4_pass_sequencer.sv | 136 +++++++++++++
 tb/tb_dct4x4_pass_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the 4x4 DCT pass sequencer.
// Blocks are 16 row-major 8-bit elements, element [0][0] in the top byte.
package dct_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N      = 4;
  localparam int unsigned BLK_W  = 128;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam blk_t IDENTITY4    = 128'h01000000_00010000_00000100_00000001;
  localparam blk_t DEFAULT_COEF = 128'h01010101_0201FFFE_01FFFF01_01FE02FF;

  function automatic logic [ELEM_W-1:0] elem(input blk_t blk, input int unsigned r,
                                             input int unsigned c);
    return blk[BLK_W-1-ELEM_W*(N*r+c) -: ELEM_W];
  endfunction

  // Pure byte rewiring; no arithmetic.
  function automatic blk_t transpose4x4(input blk_t blk);
    blk_t t;
    t = '0;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        t[BLK_W-1-ELEM_W*(N*r+c) -: ELEM_W] = elem(blk, c, r);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/dct4x4_pass_sequencer.sv
// Two-pass controller computing Y = T*X*T^T on a shared 4x4 matrix multiplier.
// Pass 1 forms T*X, pass 2 forms tmp*T^T; the result waits in DONE for out_ready.
module dct4x4_pass_sequencer
  import dct_pkg::*;
#(
  parameter blk_t        COEF     = DEFAULT_COEF,
  parameter int unsigned MULT_LAT = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  output logic [127:0]     mult_a,
  output logic [127:0]     mult_b,
  output logic             mult_req,
  input  logic [127:0]     mult_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  localparam int unsigned       WAIT_W    = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MULT_LAT);
  localparam blk_t              COEF_T    = transpose4x4(COEF);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  blk_t              x_reg, x_n;
  blk_t              tmp_reg, tmp_n;
  blk_t              out_reg, out_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              req_q, req_n;
  logic              valid_q, valid_n;

  // Next-state and register next-values
  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    x_n     = x_reg;
    tmp_n   = tmp_reg;
    out_n   = out_reg;
    cnt_n   = cnt_q;
    req_n   = 1'b0;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          x_n     = in_block;
          wait_n  = WAIT_INIT;
          req_n   = 1'b1;
          state_n = PASS1;
        end
      end
      PASS1: begin
        if (wait_cnt == '0) begin
          tmp_n   = mult_c;
          wait_n  = WAIT_INIT;
          req_n   = 1'b1;
          state_n = PASS2;
        end else begin
          wait_n = wait_cnt - 1'b1;
        end
      end
      PASS2: begin
        if (wait_cnt == '0) begin
          out_n   = mult_c;
          valid_n = 1'b1;
          state_n = DONE;
        end else begin
          wait_n = wait_cnt - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_n   = cnt_q + 1'b1;
          state_n = IDLE;
        end else begin
          valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      x_reg    <= '0;
      tmp_reg  <= '0;
      out_reg  <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      x_reg    <= x_n;
      tmp_reg  <= tmp_n;
      out_reg  <= out_n;
      cnt_q    <= cnt_n;
      req_q    <= req_n;
      valid_q  <= valid_n;
    end
  end

  // Operand steering is a pure decode of the registered state
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    case (state)
      PASS1: begin
        mult_a = COEF;
        mult_b = x_reg;
      end
      PASS2: begin
        mult_a = tmp_reg;
        mult_b = COEF_T;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mult_req  = req_q;
  assign out_valid = valid_q;
  assign out_block = out_reg;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_dct4x4_pass_sequencer.sv
// Scoreboard bench for dct4x4_pass_sequencer across three parameterisations
// (identity/2-bit counter, default coef, default coef with 2-cycle multiplier).
`timescale 1ns/1ps
module tb_dct4x4_pass_sequencer;

  localparam logic [127:0] ID4  = 128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] DEFC = 128'h01010101_0201FFFE_01FFFF01_01FE02FF;

  typedef struct {
    logic [127:0] blk;
    logic [15:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         id_iv, id_ir, id_req, id_ov, id_or, id_busy;
  logic [127:0] id_ib, id_a, id_b, id_c, id_ob;
  logic [1:0]   id_cnt;
  logic         df_iv, df_ir, df_req, df_ov, df_or, df_busy;
  logic [127:0] df_ib, df_a, df_b, df_c, df_ob;
  logic [15:0]  df_cnt;
  logic         lt_iv, lt_ir, lt_req, lt_ov, lt_or, lt_busy;
  logic [127:0] lt_ib, lt_a, lt_b, lt_c, lt_ob, lt_p1, lt_p2;
  logic [15:0]  lt_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_id[$];
  exp_t sb_df[$];
  exp_t sb_lt[$];
  logic [15:0] exp_cnt [3];
  bit          pend [3];
  logic [15:0] pend_cnt [3];

  function automatic logic [7:0] el(input logic [127:0] m, input int r, input int c);
    return m[127-8*(4*r+c) -: 8];
  endfunction

  function automatic logic [127:0] tr(input logic [127:0] m);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[127-8*(4*r+c) -: 8] = el(m, c, r);
    return t;
  endfunction

  // Reference 4x4 multiply, each element kept modulo 256
  function automatic logic [127:0] mm(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] c;
    logic [7:0]   acc;
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc + el(a, i, k) * el(b, k, j);
        c[127-8*(4*i+j) -: 8] = acc;
      end
    return c;
  endfunction

  assign id_c = mm(id_a, id_b);
  assign df_c = mm(df_a, df_b);
  always @(posedge clk) begin
    lt_p1 <= mm(lt_a, lt_b);
    lt_p2 <= lt_p1;
  end
  assign lt_c = lt_p2;

  dct4x4_pass_sequencer #(.COEF(ID4), .MULT_LAT(0), .CNT_W(2)) u_id (
    .clk(clk), .rst(rst), .in_valid(id_iv), .in_ready(id_ir), .in_block(id_ib),
    .mult_a(id_a), .mult_b(id_b), .mult_req(id_req), .mult_c(id_c),
    .out_valid(id_ov), .out_ready(id_or), .out_block(id_ob), .busy(id_busy),
    .blk_count(id_cnt));

  dct4x4_pass_sequencer #(.COEF(DEFC), .MULT_LAT(0), .CNT_W(16)) u_df (
    .clk(clk), .rst(rst), .in_valid(df_iv), .in_ready(df_ir), .in_block(df_ib),
    .mult_a(df_a), .mult_b(df_b), .mult_req(df_req), .mult_c(df_c),
    .out_valid(df_ov), .out_ready(df_or), .out_block(df_ob), .busy(df_busy),
    .blk_count(df_cnt));

  dct4x4_pass_sequencer #(.COEF(DEFC), .MULT_LAT(2), .CNT_W(16)) u_lt (
    .clk(clk), .rst(rst), .in_valid(lt_iv), .in_ready(lt_ir), .in_block(lt_ib),
    .mult_a(lt_a), .mult_b(lt_b), .mult_req(lt_req), .mult_c(lt_c),
    .out_valid(lt_ov), .out_ready(lt_or), .out_block(lt_ob), .busy(lt_busy),
    .blk_count(lt_cnt));

  function automatic logic [127:0] coef_of(input int u);
    return (u == 0) ? ID4 : DEFC;
  endfunction
  function automatic int lat_of(input int u);
    return (u == 2) ? 2 : 0;
  endfunction
  function automatic logic [127:0] golden(input int u, input logic [127:0] x);
    return mm(mm(coef_of(u), x), tr(coef_of(u)));
  endfunction

  function automatic logic get_ir(input int u);
    case (u) 0: return id_ir; 1: return df_ir; default: return lt_ir; endcase
  endfunction
  function automatic logic get_ov(input int u);
    case (u) 0: return id_ov; 1: return df_ov; default: return lt_ov; endcase
  endfunction
  function automatic logic get_or(input int u);
    case (u) 0: return id_or; 1: return df_or; default: return lt_or; endcase
  endfunction
  function automatic logic get_req(input int u);
    case (u) 0: return id_req; 1: return df_req; default: return lt_req; endcase
  endfunction
  function automatic logic get_busy(input int u);
    case (u) 0: return id_busy; 1: return df_busy; default: return lt_busy; endcase
  endfunction
  function automatic logic [127:0] get_a(input int u);
    case (u) 0: return id_a; 1: return df_a; default: return lt_a; endcase
  endfunction
  function automatic logic [127:0] get_b(input int u);
    case (u) 0: return id_b; 1: return df_b; default: return lt_b; endcase
  endfunction
  function automatic logic [127:0] get_ob(input int u);
    case (u) 0: return id_ob; 1: return df_ob; default: return lt_ob; endcase
  endfunction
  function automatic logic [15:0] get_cnt(input int u);
    case (u) 0: return {14'd0, id_cnt}; 1: return df_cnt; default: return lt_cnt; endcase
  endfunction

  task automatic set_in(input int u, input logic v, input logic [127:0] b);
    case (u)
      0: begin id_iv = v; id_ib = b; end
      1: begin df_iv = v; df_ib = b; end
      default: begin lt_iv = v; lt_ib = b; end
    endcase
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int u, input logic [127:0] y);
    exp_t e;
    exp_cnt[u] = (u == 0) ? ((exp_cnt[u] + 16'd1) & 16'd3) : (exp_cnt[u] + 16'd1);
    e.blk = y;
    e.cnt = exp_cnt[u];
    case (u) 0: sb_id.push_back(e); 1: sb_df.push_back(e); default: sb_lt.push_back(e); endcase
  endtask

  // Monitor: compares each output handshake, then the counter one cycle later
  task automatic mon(input int u);
    exp_t e;
    int   sz;
    if (pend[u]) begin
      chk($sformatf("blk_count u%0d", u), 128'(get_cnt(u)), 128'(pend_cnt[u]));
      pend[u] = 1'b0;
    end
    if (get_ov(u) && get_or(u)) begin
      case (u) 0: sz = sb_id.size(); 1: sz = sb_df.size(); default: sz = sb_lt.size(); endcase
      if (sz == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output u%0d: got %h, expected no output", u, get_ob(u));
      end else begin
        case (u) 0: e = sb_id.pop_front(); 1: e = sb_df.pop_front(); default: e = sb_lt.pop_front(); endcase
        chk($sformatf("out_block u%0d", u), get_ob(u), e.blk);
        pend[u]     = 1'b1;
        pend_cnt[u] = e.cnt;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  task automatic chk_idle_zero(input int u);
    chk($sformatf("rst in_ready u%0d", u), 128'(get_ir(u)), 128'd1);
    chk($sformatf("rst out_valid u%0d", u), 128'(get_ov(u)), 128'd0);
    chk($sformatf("rst busy u%0d", u), 128'(get_busy(u)), 128'd0);
    chk($sformatf("rst mult_req u%0d", u), 128'(get_req(u)), 128'd0);
    chk($sformatf("rst mult_a u%0d", u), get_a(u), 128'd0);
    chk($sformatf("rst mult_b u%0d", u), get_b(u), 128'd0);
    chk($sformatf("rst out_block u%0d", u), get_ob(u), 128'd0);
    chk($sformatf("rst blk_count u%0d", u), 128'(get_cnt(u)), 128'd0);
  endtask

  task automatic wait_ready(input int u);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (get_ir(u)) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("in_ready timeout u%0d", u), 128'(seen), 128'd1);
  endtask

  // Measure cycles from the input handshake to out_valid; also checks operands and mult_req
  task automatic track(input int u, input logic [127:0] x, input bit no_ir);
    int lat, reqs, irs, l;
    l = lat_of(u);
    lat = 0; reqs = 0; irs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (get_req(u)) reqs++;
      if (get_ir(u)) irs++;
      if (lat == 1) begin
        chk($sformatf("pass1 mult_a u%0d", u), get_a(u), coef_of(u));
        chk($sformatf("pass1 mult_b u%0d", u), get_b(u), x);
      end
      if (lat == l + 2) begin
        chk($sformatf("pass2 mult_a u%0d", u), get_a(u), mm(coef_of(u), x));
        chk($sformatf("pass2 mult_b u%0d", u), get_b(u), tr(coef_of(u)));
      end
      if (get_ov(u)) break;
    end
    chk($sformatf("latency u%0d", u), 128'(lat), 128'(2 * l + 3));
    chk($sformatf("mult_req pulses u%0d", u), 128'(reqs), 128'd2);
    if (no_ir) chk($sformatf("in_ready while busy u%0d", u), 128'(irs), 128'd0);
  endtask

  task automatic run_block(input int u, input logic [127:0] x, input logic [127:0] y);
    push_exp(u, y);
    wait_ready(u);
    @(posedge clk); #1 set_in(u, 1'b1, x);
    @(posedge clk); #1 set_in(u, 1'b0, '0);
    track(u, x, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] xi, xo, x1, x2, x3;
    logic [127:0] id_vec [5];
    xi = 128'h00010002_00000204_00040301_00000805;
    xo = 128'h04050607_01030000_01000206_06040405;
    x1 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    x2 = xo;
    x3 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    id_vec[0] = xi;
    id_vec[1] = ~xi;
    id_vec[2] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    id_vec[3] = 128'hFFFFFFFF_00000000_80808080_7F7F7F7F;
    id_vec[4] = xi;
    for (int u = 0; u < 3; u++) begin
      exp_cnt[u] = '0;
      set_in(u, 1'b0, '0);
    end
    id_or = 1'b1; df_or = 1'b1; lt_or = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) chk_idle_zero(u);
    @(posedge clk); #1 rst = 1'b0;

    // Identity transform and 2-bit counter wrap: counts 1,2,3,0,1
    for (int i = 0; i < 5; i++) run_block(0, id_vec[i], id_vec[i]);

    // Default coefficients, combinational multiplier
    run_block(1, xo, golden(1, xo));
    run_block(1, x3, golden(1, x3));

    // Two-cycle multiplier with output back-pressure and a held second request
    @(posedge clk); #1 lt_or = 1'b0;
    push_exp(2, golden(2, x1));
    wait_ready(2);
    @(posedge clk); #1 set_in(2, 1'b1, x1);
    @(posedge clk); #1 set_in(2, 1'b1, x2);
    track(2, x1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid", 128'(lt_ov), 128'd1);
      chk("bp out_block", lt_ob, golden(2, x1));
      chk("bp in_ready", 128'(lt_ir), 128'd0);
    end
    push_exp(2, golden(2, x2));
    @(posedge clk); #1 lt_or = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp idle in_ready", 128'(lt_ir), 128'd1);
    @(posedge clk); #1 set_in(2, 1'b0, '0);
    track(2, x2, 1'b1);

    // Reset in the second PASS2 cycle discards the block
    wait_ready(2);
    @(posedge clk); #1 set_in(2, 1'b1, x3);
    @(posedge clk); #1 set_in(2, 1'b0, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre-rst pass2 mult_b", lt_b, tr(DEFC));
    chk("pre-rst busy", 128'(lt_busy), 128'd1);
    rst = 1'b1;
    #1;
    chk_idle_zero(2);
    chk("mid-rst blk_count u0", 128'(id_cnt), 128'd0);
    chk("mid-rst blk_count u1", 128'(df_cnt), 128'd0);
    for (int u = 0; u < 3; u++) exp_cnt[u] = '0;
    @(posedge clk); #1 rst = 1'b0;
    run_block(2, x3, golden(2, x3));
    run_block(0, xi, xi);
    run_block(1, xo, golden(1, xo));

    repeat (3) @(negedge clk);
    chk("scoreboard drained u0", 128'(sb_id.size()), 128'd0);
    chk("scoreboard drained u1", 128'(sb_df.size()), 128'd0);
    chk("scoreboard drained u2", 128'(sb_lt.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
